fetch_unit: RTL and testbench

Instruction fetch front end that supplies the control unit with its instruction word. It keeps the program counter, reads 16-bit instructions from instruction memory over a req/ack handshake, and buffers them in the instruction register. The opcode field `ir[15:11]` goes to the control unit's decision state. The control unit consumes an instruction by pulsing `ir_take`.

---
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: program counter, req/ack instruction-memory reads, instruction buffer.
// Optional macro FETCH_PREFETCH_EN selects a two-entry buffer that prefetches ahead of the control unit.
module fetch_unit #(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   mem_req,
    output logic [PC_WIDTH-1:0]    mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic [INSTR_WIDTH-1:0] ir,
    output logic [4:0]             opcode,
    output logic [PC_WIDTH-1:0]    ir_pc,
    output logic                   ir_valid,
    input  logic                   ir_take,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc
);

`ifdef FETCH_PREFETCH_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    // IDLE exists only so mem_req is low during reset and rises one cycle after release.
    typedef enum logic [1:0] {IDLE, FETCH, FULL, DISCARD} state_t;

    state_t                 state, state_nxt;
    logic [PC_WIDTH-1:0]    fetch_pc;
    logic [PC_WIDTH-1:0]    stale_pc;
    logic [1:0]             count, count_nxt;
    logic [INSTR_WIDTH-1:0] head_ir;
    logic [PC_WIDTH-1:0]    head_pc;
    logic                   ack, push, pop;

    assign mem_req  = (state == FETCH) || (state == DISCARD);
    assign mem_addr = (state == DISCARD) ? stale_pc : fetch_pc;
    assign ack      = mem_req && mem_ack;
    assign pop      = ir_take && (count != 2'd0) && !redirect;
    assign push     = ack && (state == FETCH) && !redirect;

    always_comb begin
        count_nxt = count;
        if (redirect)
            count_nxt = 2'd0;
        else if (push && !pop)
            count_nxt = count + 2'd1;
        else if (pop && !push)
            count_nxt = count - 2'd1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH: begin
                // An outstanding read cannot be cancelled, so a redirect waits it out in DISCARD.
                if (redirect)
                    state_nxt = ack ? FETCH : DISCARD;
                else if (ack)
                    state_nxt = (count_nxt < DEPTH) ? FETCH : FULL;
            end
            FULL:    if (redirect || pop) state_nxt = FETCH;
            DISCARD: if (ack) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= 2'd0;
            fetch_pc <= RESET_PC;
            stale_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (redirect)
                fetch_pc <= redirect_pc;
            else if (push)
                fetch_pc <= fetch_pc + PC_WIDTH'(1);
            // Hold the in-flight address so mem_addr stays put while fetch_pc moves on.
            if ((state == FETCH) && redirect && !ack)
                stale_pc <= fetch_pc;
        end
    end

`ifdef FETCH_PREFETCH_EN
    logic [INSTR_WIDTH-1:0] tail_ir;
    logic [PC_WIDTH-1:0]    tail_pc;
    logic                   push_head;

    // A push lands in the head when the buffer is empty or its only entry leaves this cycle.
    assign push_head = (count == 2'd0) || (pop && (count == 2'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ir <= '0;
            head_pc <= '0;
            tail_ir <= '0;
            tail_pc <= '0;
        end else begin
            if (push && push_head) begin
                head_ir <= mem_rdata;
                head_pc <= fetch_pc;
            end else if (pop && (count == 2'd2)) begin
                head_ir <= tail_ir;
                head_pc <= tail_pc;
            end
            if (push && !push_head) begin
                tail_ir <= mem_rdata;
                tail_pc <= fetch_pc;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ir <= '0;
            head_pc <= '0;
        end else if (push) begin
            head_ir <= mem_rdata;
            head_pc <= fetch_pc;
        end
    end
`endif

    assign ir       = head_ir;
    assign opcode   = head_ir[INSTR_WIDTH-1 -: 5];
    assign ir_pc    = head_pc;
    assign ir_valid = (count != 2'd0);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized phase,
// scored against an in-order address sequence and a memory content function.
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] ir;
    logic [4:0]  opcode;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        ir_take = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;

    fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir(ir), .opcode(opcode), .ir_pc(ir_pc), .ir_valid(ir_valid),
        .ir_take(ir_take), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    int ack_delay = 0, wait_cnt = 0, n_acks = 0, n_takes = 0;
    bit rand_mode = 0, mem_mode = 0;
    logic [7:0] exp_pc = '0;
    logic [7:0] ack_log[$];

    bit         p_req, p_ack, p_valid, p_take, p_redir, p_busy;
    logic [7:0] p_addr, p_rpc, p_irpc;
    logic [15:0] p_ir;

    function automatic logic [15:0] mem_func(input logic [7:0] a);
        if (mem_mode) return {a ^ 8'h5A, a};
        return 16'h4000 + {8'h00, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: memory responds and inputs are driven at the falling edge, checks run, then the rising edge.
    task automatic cycle(input bit take, input bit redir, input logic [7:0] rpc);
        logic [15:0] d;
        @(negedge clk);
        ir_take = take; redirect = redir; redirect_pc = rpc;
        mem_ack = 1'b0; mem_rdata = '0;
        if (mem_req) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack = 1'b1; mem_rdata = mem_func(mem_addr);
                wait_cnt = 0; n_acks++; ack_log.push_back(mem_addr);
                if (rand_mode) ack_delay = $urandom_range(0, 3);
            end else wait_cnt++;
        end else if (rand_mode && $urandom_range(0, 7) == 0) begin
            mem_ack = 1'b1; mem_rdata = 16'($urandom);
        end
        if (p_req && !p_ack) begin
            chk("req_hold", mem_req, 1);
            chk("addr_hold", mem_addr, p_addr);
        end
        if (p_redir) chk("redir_flush", ir_valid, 0);
        if (p_redir && !p_busy) begin
            chk("redir_req", mem_req, 1);
            chk("redir_addr", mem_addr, p_rpc);
        end
        if (p_valid && !p_take && !p_redir) begin
            chk("ir_hold_valid", ir_valid, 1);
            chk("ir_hold", {ir_pc, ir}, {p_irpc, p_ir});
        end
        if (ir_valid) begin
            d = mem_func(ir_pc);
            chk("ir_data", ir, d);
            chk("opcode", opcode, d[15:11]);
            if (take && !redir) begin
                chk("ir_pc_seq", ir_pc, exp_pc);
                exp_pc++; n_takes++;
            end
        end
        if (redir) exp_pc = rpc;
        p_req = mem_req; p_ack = mem_ack; p_addr = mem_addr; p_valid = ir_valid;
        p_take = take; p_redir = redir; p_rpc = rpc; p_busy = mem_req && !mem_ack;
        p_ir = ir; p_irpc = ir_pc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ir_take = 0; redirect = 0; mem_ack = 0;
        #1 chk("rst_async_req", mem_req, 0);
        @(negedge clk);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_ir", ir, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_ir_pc", ir_pc, 0);
        chk("rst_valid", ir_valid, 0);
        rst_n = 1'b1;
        wait_cnt = 0; exp_pc = 8'h00;
        {p_req, p_ack, p_valid, p_take, p_redir, p_busy} = '0;
        @(posedge clk);
        #1;
        chk("first_req", mem_req, 1);
        chk("first_addr", mem_addr, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int base;

        // Zero-wait memory, take every cycle: throughput depends on buffer depth.
        ack_delay = 0;
        do_reset();
        n_takes = 0;
        for (int i = 0; i < 20; i++) cycle(1, 0, 8'h00);
        chk("throughput", n_takes, (DEPTH == 2) ? 19 : 10);

        // Take held low: buffer fills to DEPTH then requests stop.
        do_reset();
        n_acks = 0;
        for (int i = 0; i < 6; i++) cycle(0, 0, 8'h00);
        chk("fill_acks", n_acks, DEPTH);
        chk("fill_req_low", mem_req, 0);
        chk("fill_head", ir_pc, 8'h00);
        chk("fill_head_ir", ir, 16'h4000);
        cycle(1, 0, 8'h00);
        chk("take_req", mem_req, 1);
        chk("take_addr", mem_addr, DEPTH);
        chk("take_valid", ir_valid, (DEPTH == 2) ? 1 : 0);
        if (DEPTH == 2) chk("take_next_pc", ir_pc, 8'h01);

        // 3-cycle memory, redirect while the read for 0x05 is in flight.
        ack_delay = 3;
        do_reset();
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            cycle(1, 0, 8'h00);
            if (mem_req && mem_addr == 8'h05) found = 1;
        end
        chk("find_req5", found, 1);
        cycle(1, 0, 8'h00);
        base = n_acks;
        cycle(0, 1, 8'h40);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(0, 0, 8'h00);
            if (mem_addr != 8'h05) found = 1;
        end
        chk("stale_done", found, 1);
        chk("stale_acks", n_acks - base, 1);
        chk("redir_req40", mem_req, 1);
        chk("redir_addr40", mem_addr, 8'h40);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (ir_valid) found = 1;
            else cycle(0, 0, 8'h00);
        end
        chk("redir_valid", found, 1);
        chk("redir_ir_pc", ir_pc, 8'h40);
        chk("redir_ir", ir, 16'h4040);

        // Redirect together with take (and, with prefetch, an ack) while one entry is held.
        ack_delay = 0;
        do_reset();
        cycle(0, 0, 8'h00);
        chk("coinc_valid", ir_valid, 1);
        chk("coinc_req", mem_req, (DEPTH == 2) ? 1 : 0);
        cycle(1, 1, 8'h80);
        chk("coinc_flush", ir_valid, 0);
        chk("coinc_addr", mem_addr, 8'h80);
        for (int i = 0; i < 4; i++) cycle(1, 0, 8'h00);

        // Address wrap after redirect to the top of memory.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00);
        cycle(0, 1, 8'hFF);
        ack_log.delete();
        for (int i = 0; i < 6; i++) cycle(1, 0, 8'h00);
        chk("wrap_count", ack_log.size() >= 2, 1);
        if (ack_log.size() >= 2) begin
            chk("wrap_first", ack_log[0], 8'hFF);
            chk("wrap_second", ack_log[1], 8'h00);
        end

        // Reset while a read is outstanding.
        ack_delay = 3;
        do_reset();
        cycle(0, 0, 8'h00);
        cycle(0, 0, 8'h00);
        chk("pre_rst_req", mem_req, 1);
        ack_delay = 1;
        do_reset();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (ir_valid) found = 1;
            else cycle(0, 0, 8'h00);
        end
        chk("rst_restart_valid", found, 1);
        chk("rst_restart_pc", ir_pc, 8'h00);

        // Randomized traffic: variable latency, random takes, redirects and stray acks.
        mem_mode = 1; rand_mode = 1; ack_delay = 1;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0)
                cycle(1'($urandom), 1, 8'($urandom));
            else
                cycle($urandom_range(0, 2) != 0, 0, 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
